// File: rtl/vga_pmod_receiver.sv
// TinyVGA PMOD receiver: samples the PMOD bus, unpacks sync/RGB, rebuilds
// raster coordinates from the sync edges, verifies timing and streams active
// pixels together with a per-frame checksum.
module vga_pmod_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pmod_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        err_line,
  output logic        err_frame
);

  localparam int H_START = H_SYNC + H_BACK;
  localparam int H_END   = H_START + H_ACTIVE - 1;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int V_END   = V_START + V_ACTIVE - 1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_reg;
  logic [7:0]  in_reg;
  logic [1:0]  prev_sync_reg;   // {hsync, vsync} of the previous sample
  logic [10:0] h_reg;
  logic [9:0]  v_reg;
  logic [5:0]  rgb_reg;
  logic        line_fail_reg;
  logic        done_p_reg;
  logic        err_line_p_reg;
  logic        err_frame_p_reg;
  logic        clr_p_reg;
  logic [15:0] acc_reg;

  logic        hs_fall;
  logic        vs_fall;
  logic [10:0] h_inc;
  logic        h_sat;
  logic        period_bad;
  logic [9:0]  v_inc;
  logic [10:0] frame_lines;
  logic        lines_ok;
  logic        active_now;
  logic [10:0] x_full;

  // Input capture; syncs idle high out of reset so no false edge is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_reg        <= 8'h88;
      prev_sync_reg <= 2'b11;
    end else begin
      in_reg        <= pmod_in;
      prev_sync_reg <= {in_reg[7], in_reg[3]};
    end
  end

  assign hs_fall     = prev_sync_reg[1] & ~in_reg[7];
  assign vs_fall     = prev_sync_reg[0] & ~in_reg[3];
  assign h_inc       = (h_reg == 11'h7FF) ? h_reg : h_reg + 11'd1;
  // Fires once, on the sample where the counter first reaches its ceiling.
  assign h_sat       = !hs_fall && (h_reg == 11'h7FE);
  assign period_bad  = hs_fall && (h_inc != 11'(H_TOTAL));
  assign v_inc       = (v_reg == 10'h3FF) ? v_reg : v_reg + 10'd1;
  assign frame_lines = {1'b0, v_reg} + {10'd0, hs_fall};
  assign lines_ok    = (frame_lines == 11'(V_TOTAL));

  // Raster counters and lock FSM; event pulses staged for the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= SEARCH;
      h_reg           <= 11'd0;
      v_reg           <= 10'd0;
      rgb_reg         <= 6'd0;
      line_fail_reg   <= 1'b0;
      done_p_reg      <= 1'b0;
      err_line_p_reg  <= 1'b0;
      err_frame_p_reg <= 1'b0;
      clr_p_reg       <= 1'b0;
    end else begin
      h_reg   <= hs_fall ? 11'd0 : h_inc;
      rgb_reg <= {in_reg[0], in_reg[4], in_reg[1], in_reg[5], in_reg[2], in_reg[6]};
      if (vs_fall) begin
        v_reg <= 10'd0;
      end else if (hs_fall) begin
        v_reg <= v_inc;
      end
      clr_p_reg       <= vs_fall;
      done_p_reg      <= 1'b0;
      err_line_p_reg  <= 1'b0;
      err_frame_p_reg <= 1'b0;
      case (state_reg)
        SEARCH: begin
          if (vs_fall) begin
            state_reg     <= MEASURE;
            line_fail_reg <= 1'b0;
          end
        end
        MEASURE: begin
          if (h_sat) begin
            state_reg      <= SEARCH;
            err_line_p_reg <= 1'b1;
          end else if (vs_fall) begin
            if (!line_fail_reg && !period_bad && lines_ok) begin
              state_reg <= LOCKED;
            end else begin
              err_line_p_reg  <= line_fail_reg | period_bad;
              err_frame_p_reg <= !lines_ok;
            end
            line_fail_reg <= 1'b0;
          end else if (period_bad) begin
            line_fail_reg <= 1'b1;
          end
        end
        LOCKED: begin
          if (h_sat || period_bad) begin
            state_reg      <= SEARCH;
            err_line_p_reg <= 1'b1;
          end else if (vs_fall) begin
            if (!lines_ok) begin
              state_reg       <= MEASURE;
              err_frame_p_reg <= 1'b1;
              line_fail_reg   <= 1'b0;
            end else begin
              done_p_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

  assign active_now = (state_reg == LOCKED) &&
                      (h_reg >= 11'(H_START)) && (h_reg <= 11'(H_END)) &&
                      (v_reg >= 10'(V_START)) && (v_reg <= 10'(V_END));
  assign x_full     = h_reg - 11'(H_START);

  // Output register stage: pixel stream, status, pulses and checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      pix_rgb    <= 6'd0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= 16'd0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      acc_reg    <= 16'd0;
    end else begin
      pix_valid  <= active_now;
      locked     <= (state_reg == LOCKED);
      frame_done <= done_p_reg;
      err_line   <= err_line_p_reg;
      err_frame  <= err_frame_p_reg;
      if (active_now) begin
        pix_x   <= x_full[9:0];
        pix_y   <= v_reg - 10'(V_START);
        pix_rgb <= rgb_reg;
      end
      if (clr_p_reg) begin
        // A new frame starts here; hand off the finished sum if it was good.
        if (done_p_reg) begin
          frame_sum <= acc_reg;
        end
        acc_reg <= active_now ? {10'd0, rgb_reg} : 16'd0;
      end else if (active_now) begin
        acc_reg <= acc_reg + {10'd0, rgb_reg};
      end
    end
  end

endmodule

// File: tb/tb_vga_pmod_receiver.sv
// Directed bench for vga_pmod_receiver on a shrunken raster: scoreboarded
// pixel stream plus lock/error/checksum event checks.
module tb_vga_pmod_receiver;

  localparam int HA = 16;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HT = 28;
  localparam int VA = 8;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pmod_in = 8'h88;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  pix_rgb;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic        err_line;
  logic        err_frame;

  typedef struct {
    int x;
    int y;
    int rgb;
  } px_t;

  px_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  pix_cnt = 0;
  int  done_cnt = 0;
  int  el_cnt = 0;
  int  ef_cnt = 0;
  int  last_sum = 0;

  always #5 clk = ~clk;

  vga_pmod_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum),
    .err_line(err_line), .err_frame(err_frame)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] make_pmod(input bit hs, input bit vs, input logic [5:0] rgb);
    return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
  endfunction

  task automatic tick(input logic [7:0] val);
    @(posedge clk);
    #1 pmod_in = val;
  endtask

  // pat 0: every active pixel rgb 101010; pat 1: black except pixel (5,3).
  task automatic drive_frame(input int nlines, input int long_line, input int pat, input bit exp_px);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = HT + ((l == long_line) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        bit         hs_b;
        bit         vs_b;
        bit         act;
        int         x;
        int         y;
        logic [5:0] rgb;
        logic [7:0] b;
        hs_b = (h >= HS);
        vs_b = (l >= VS);
        act  = (h >= HS + HB) && (h < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        x    = h - HS - HB;
        y    = l - VS - VB;
        rgb  = 6'd0;
        b    = make_pmod(hs_b, vs_b, 6'd0);
        if (act) begin
          if (pat == 0) begin
            rgb = 6'b101010;
            b   = make_pmod(hs_b, vs_b, rgb);
          end else if (x == 5 && y == 3) begin
            rgb = 6'b000001;
            b   = 8'b1100_1000;
          end
          if (exp_px) begin
            exp_q.push_back('{x: x, y: y, rgb: int'(rgb)});
          end
        end
        tick(b);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_x"}, pix_x, 0);
    check({tag, "_y"}, pix_y, 0);
    check({tag, "_rgb"}, pix_rgb, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_sum"}, frame_sum, 0);
    check({tag, "_errl"}, err_line, 0);
    check({tag, "_errf"}, err_frame, 0);
  endtask

  // Output monitor: pops the scoreboard on every pixel, tallies event pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        pix_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_pix", pix_valid, 0);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("pix_rgb", pix_rgb, e.rgb);
        end
      end
      if (frame_done) begin
        done_cnt++;
        last_sum = frame_sum;
        check("done_with_errframe", err_frame, 0);
      end
      if (err_line) el_cnt++;
      if (err_frame) ef_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 pmod_in = 8'($urandom);
    end
    check_all_zero("rst");
    $display("step reset held: locked=%0d", locked);
    pmod_in = 8'h88;
    rst_n   = 1'b1;
    repeat (5) tick(8'h88);
    check_all_zero("idle");
    $display("step idle after release: locked=%0d", locked);

    drive_frame(VT, -1, 0, 1'b0);                    // F1: measure
    check("f1_locked", locked, 0);
    $display("step F1 measured: locked=%0d", locked);

    drive_frame(VT, -1, 0, 1'b1);                    // F2: locked, full pattern
    check("f2_locked", locked, 1);
    check("f2_pix_cnt", pix_cnt, HA * VA);
    check("f2_q_empty", exp_q.size(), 0);
    check("f2_done_cnt", done_cnt, 0);
    $display("step F2 locked frame: pixels=%0d", pix_cnt);

    drive_frame(VT, -1, 1, 1'b1);                    // F3: single-pixel pattern
    check("f3_done_cnt", done_cnt, 1);
    check("f3_sum", last_sum, (HA * VA * 42) % 65536);
    check("f3_pix_cnt", pix_cnt, 2 * HA * VA);
    $display("step F3 bit-map frame: sum_of_f2=%0d", last_sum);

    drive_frame(VT, 1, 0, 1'b0);                     // F4: one 29-clock line
    check("f4_done_cnt", done_cnt, 2);
    check("f4_sum", last_sum, 1);
    check("f4_err_line", el_cnt, 1);
    check("f4_locked", locked, 0);
    $display("step F4 long line: err_line=%0d locked=%0d", el_cnt, locked);

    drive_frame(VT, -1, 0, 1'b0);                    // F5: search -> measure
    drive_frame(VT, -1, 0, 1'b1);                    // F6: relocked
    check("f6_done_cnt", done_cnt, 2);
    check("f6_locked", locked, 1);
    drive_frame(VT - 1, -1, 0, 1'b1);                // F7: short frame, vs7 = done
    check("f7_done_cnt", done_cnt, 3);
    check("f7_sum", last_sum, (HA * VA * 42) % 65536);
    $display("step F7 short frame driven: frame_done=%0d", done_cnt);

    drive_frame(VT, -1, 0, 1'b0);                    // F8: err_frame at its start
    check("f8_err_frame", ef_cnt, 1);
    check("f8_done_cnt", done_cnt, 3);
    check("f8_locked", locked, 0);
    $display("step F8 after short frame: err_frame=%0d", ef_cnt);

    drive_frame(VT, -1, 0, 1'b1);                    // F9: relocked
    check("f9_locked", locked, 1);
    check("f9_done_cnt", done_cnt, 3);
    repeat (3000) tick(8'h88);                       // hsync stuck high
    check("sat_err_line", el_cnt, 2);
    check("sat_locked", locked, 0);
    check("sat_done_cnt", done_cnt, 3);
    check("sat_q_empty", exp_q.size(), 0);
    $display("step hsync stuck: err_line=%0d locked=%0d", el_cnt, locked);

    drive_frame(VT, -1, 0, 1'b0);                    // F10: measure
    drive_frame(VS + VB + 2, -1, 0, 1'b1);           // F11: partial locked frame
    repeat (3) tick(make_pmod(1'b1, 1'b1, 6'd0));
    check("f11_locked", locked, 1);
    check("f11_q_empty", exp_q.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 check_all_zero("midrst");
    $display("step mid-frame reset: locked=%0d", locked);
    rst_n = 1'b1;
    drive_frame(VT, -1, 0, 1'b0);                    // F12: needs full relock
    check("f12_locked", locked, 0);
    check("f12_err_line", el_cnt, 2);
    check("f12_err_frame", ef_cnt, 1);
    check("end_q_empty", exp_q.size(), 0);
    $display("step post-reset frame: locked=%0d", locked);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_pmod_receiver.md
# vga_pmod_receiver

Receive side of the TinyVGA PMOD interface. The block samples the 8-bit PMOD bus that our VGA generators drive, unpacks sync and 6-bit RGB, and rebuilds pixel coordinates from the sync edges. It locks onto a 640x480 / 800x525 raster and streams active pixels with a per-frame checksum. It sits on `uio_in` for loopback self-test of the glyph-mode display and as a bench monitor.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch
- `H_TOTAL`, 800, clocks per line
- `V_ACTIVE`, 480, active lines
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch
- `V_TOTAL`, 525, lines per frame

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset; synchronous, active-low
- `pmod_in`  in  8  {hsync, RGB[0], RGB[2], RGB[4], vsync, RGB[1], RGB[3], RGB[5]}; syncs active-low
- `pix_valid`  out  1  active pixel strobe (only while locked)
- `pix_x`  out  10  column 0..H_ACTIVE-1
- `pix_y`  out  10  row 0..V_ACTIVE-1
- `pix_rgb`  out  6  unpacked RGB[5:0]
- `locked`  out  1  raster timing verified
- `frame_done`  out  1  one-cycle pulse at the end of each good locked frame
- `frame_sum`  out  16  sum of `pix_rgb` over the valid pixels of the frame; updates with `frame_done`
- `err_line`  out  1  one-cycle pulse, bad line period or hsync lost
- `err_frame`  out  1  one-cycle pulse, bad line count

## Operation
- Input stage: `pmod_in` is registered every cycle. The reset value is 8'h88 (syncs idle high). A second register holds the previous sample for edge detection.
- Unpack: `pix_rgb` = {b0, b4, b1, b5, b2, b6} of the sample.
- Horizontal index h (11 bit):
  - The first sample with hsync low after a high sample has h = 0 (hs_fall).
  - Each following sample increments h, saturating at 2047.
  - At hs_fall, the line period is the h value the counter would have reached, which is 800 for nominal timing.
- Vertical index v (10 bit):
  - v is set to 0 on the vsync-low edge sample (vs_fall).
  - v increments on each hs_fall and saturates at 1023.
  - If vs_fall and hs_fall occur on the same sample, vs_fall wins and v = 0.
  - frame_lines = v + hs_fall, evaluated at vs_fall.
- Active region:
  - h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] gives x = h-144.
  - v in [V_SYNC+V_BACK, +V_ACTIVE-1] gives y = v-35.
- Lock FSM:
  - SEARCH (reset state): wait for vs_fall, then go to MEASURE and clear the line-fail flag.
  - MEASURE:
    - Any hs_fall with period != H_TOTAL sets the line-fail flag.
    - At vs_fall: if the flag is clear and frame_lines == V_TOTAL, go to LOCKED. Otherwise pulse the matching error, stay in MEASURE and clear the flag.
    - h saturating at 2047 sends the FSM to SEARCH and pulses `err_line`.
  - LOCKED:
    - An hs_fall with bad period, or h saturating, pulses `err_line` and goes to SEARCH.
    - At vs_fall, frame_lines != V_TOTAL pulses `err_frame` and goes to MEASURE.
    - Otherwise at vs_fall, pulse `frame_done`, present `frame_sum`, and clear the accumulator.
- Checksum: a 16-bit accumulator adds `pix_rgb` on every `pix_valid` (wraps mod 2^16). It is cleared on entry to LOCKED and on every vs_fall.
- `locked` = state is LOCKED.

## Timing
- Reset:
  - All outputs are 0 and the FSM is in SEARCH.
  - h = 0, v = 0, accumulator = 0.
  - Input registers are 8'h88.
  - Reset asserted mid-frame takes effect at the next edge, and a full relock is required.
- Latency: the sample of `pmod_in` at edge n appears on `pix_*` at edge n+2. All outputs are registered.
- `locked` rises 2 cycles after the `pmod_in` sample carrying the vs_fall that completes a good MEASURE frame.
  - The earliest lock is at the second vs_fall after reset.
  - `pix_valid` first asserts on the following frame's active region.
- `frame_done`, `err_line` and `err_frame` are single-cycle pulses, 2 cycles after the triggering sample. `frame_done` and `err_frame` never coincide.
- `pix_valid` drops in the same cycle that `locked` drops. No partial-frame `frame_done` is emitted.

## Test plan
- Reset: `rst_n` low for 3 cycles with random `pmod_in` -> all outputs 0, `locked` 0. Release with syncs idle -> outputs stay 0.
- Nominal raster, every active pixel `pmod_in` giving rgb 6'b101010:
  - `locked` rises at the 2nd vs_fall.
  - The next frame has exactly 307200 `pix_valid` cycles, the first at (0,0) and the last at (639,479).
  - `frame_done` fires with `frame_sum` = 16'd57344.
- Bit mapping: a black frame except pixel (5,3) with `pmod_in` = 8'b1100_1000 -> a single `pix_valid` with rgb 6'b000001 at x=5, y=3, and `frame_sum` = 1.
- While locked, stretch one line to 801 clocks -> `err_line` pulses once and `locked` falls. The first `frame_done` is at the 3rd good vs_fall after the error.
- While locked, a 524-line frame -> `err_frame` at that vs_fall, `locked` 0, no `frame_done`. Relock at the next good vs_fall.
- Hold hsync high for 3000 clocks while locked -> `err_line` at h saturation, FSM to SEARCH. `rst_n` low mid-frame -> all outputs 0 on the next cycle.
